// File: rtl/reg_write_arbiter_if.sv
// Requester-side bundle for the shared-register write arbiter.
// The master drives requests and data; the slave returns grant and register state.
interface reg_write_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       lock;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      Q;
    logic [2:0]            owner;
    logic [7:0]            wr_cnt;

    modport master (
        output req, lock, wdata,
        input  gnt, Q, owner, wr_cnt
    );

    modport slave (
        input  req, lock, wdata,
        output gnt, Q, owner, wr_cnt
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter that owns one shared register and lets the
// granted requester write it for one cycle or a locked burst.
module reg_write_arbiter #(
    parameter int WIDTH     = 8,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 clr,
    reg_write_arbiter_if.slave   bus
);

    typedef enum logic {IDLE, OWN} state_t;

    state_t           state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [2:0]       owner_q, owner_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [2:0]       rr_q, rr_d;
    logic [3:0]       burst_q, burst_d;

    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0]   rot;
    logic [2:0]        off;
    logic [3:0]        sum;
    logic [2:0]        win;
    logic [3:0]        win_p1;
    logic              own_req;
    logic              own_lock;
    logic [WIDTH-1:0]  own_data;
    logic [3:0]        burst_p1;

    // Rotate requests so rr_q sits at bit 0; lowest set bit wins.
    always_comb begin
        req_dbl = {bus.req, bus.req} >> rr_q;
        rot     = req_dbl[NREQ-1:0];
        off     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) off = 3'(k);
        end
        sum = {1'b0, rr_q} + {1'b0, off};
        if (sum >= 4'(NREQ)) sum = sum - 4'(NREQ);
        win    = sum[2:0];
        win_p1 = {1'b0, win} + 4'd1;
        if (win_p1 == 4'(NREQ)) win_p1 = '0;
    end

    always_comb begin
        own_req  = 1'b0;
        own_lock = 1'b0;
        own_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_q == 3'(i)) begin
                own_req  = bus.req[i];
                own_lock = bus.lock[i];
                own_data = bus.wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    assign burst_p1 = burst_q + 4'd1;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        q_d     = q_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        burst_d = burst_q;
        unique case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d = OWN;
                    gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << win;
                    owner_d = win;
                    rr_d    = win_p1[2:0];
                    burst_d = '0;
                end
            end
            OWN: begin
                if (own_req) begin
                    q_d     = own_data;
                    cnt_d   = cnt_q + 8'd1;
                    burst_d = burst_p1;
                    if (!own_lock || burst_p1 == 4'(MAX_BURST)) begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            q_q     <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            rr_q    <= '0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            q_q     <= q_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            burst_q <= burst_d;
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.Q      = q_q;
    assign bus.owner  = owner_q;
    assign bus.wr_cnt = cnt_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: a vector table for round-robin,
// bursts, early drop and wrap, plus hand sequences for reset and counter wrap.
module tb_reg_write_arbiter;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;

    logic clk;
    logic clr;
    int   errors;
    int   checks;

    reg_write_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

    reg_write_arbiter #(
        .WIDTH(WIDTH),
        .NREQ(NREQ),
        .MAX_BURST(4)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  lock;
        logic [31:0] wdata;
        logic [3:0]  gnt;
        logic [7:0]  q;
        logic [2:0]  own;
        logic [7:0]  cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [3:0] r, logic [3:0] l,
                                logic [31:0] w, logic [3:0] g,
                                logic [7:0] q, logic [2:0] o,
                                logic [7:0] c);
        vec_t v;
        v.req = r; v.lock = l; v.wdata = w;
        v.gnt = g; v.q = q; v.own = o; v.cnt = c;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(logic [3:0] r, logic [3:0] l, logic [31:0] w);
        bus.req   = r;
        bus.lock  = l;
        bus.wdata = w;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(4'b0, 4'b0, 32'h0);
        clr = 1'b0;
        #12;
        clr = 1'b1;
        #2;
    endtask

    localparam logic [31:0] BASE = 32'h44332211;

    initial begin
        errors = 0;
        checks = 0;
        clr    = 1'b1;
        drive(4'b0, 4'b0, 32'h0);
        #3;
        do_reset();
        @(negedge clk);
        chk("rst_gnt", 32'(bus.gnt), 32'h0);
        chk("rst_q", 32'(bus.Q), 32'h0);
        chk("rst_cnt", 32'(bus.wr_cnt), 32'h0);

        // Reset in the middle of a locked burst by requester 1.
        drive(4'b0010, 4'b0010, 32'h00005A00);
        step();
        chk("mb_gnt", 32'(bus.gnt), 32'h2);
        step();
        step();
        chk("mb_q", 32'(bus.Q), 32'h5A);
        chk("mb_cnt", 32'(bus.wr_cnt), 32'h2);
        chk("mb_gnt_held", 32'(bus.gnt), 32'h2);
        #2;
        clr = 1'b0;
        #1;
        chk("mb_rst_gnt", 32'(bus.gnt), 32'h0);
        chk("mb_rst_q", 32'(bus.Q), 32'h0);
        chk("mb_rst_cnt", 32'(bus.wr_cnt), 32'h0);
        chk("mb_rst_own", 32'(bus.owner), 32'h0);
        @(negedge clk);
        clr = 1'b1;
        drive(4'b0011, 4'b0000, BASE);
        step();
        chk("mb_regrant", 32'(bus.gnt), 32'h1);

        do_reset();

        vecs.push_back(mk(4'b1111, 4'h0, BASE, 4'b0001, 8'h00, 3'd0, 8'd0));
        vecs.push_back(mk(4'b1111, 4'h0, BASE, 4'b0000, 8'h11, 3'd0, 8'd1));
        vecs.push_back(mk(4'b1111, 4'h0, BASE, 4'b0010, 8'h11, 3'd1, 8'd1));
        vecs.push_back(mk(4'b1111, 4'h0, BASE, 4'b0000, 8'h22, 3'd1, 8'd2));
        vecs.push_back(mk(4'b1111, 4'h0, BASE, 4'b0100, 8'h22, 3'd2, 8'd2));
        vecs.push_back(mk(4'b1111, 4'h0, BASE, 4'b0000, 8'h33, 3'd2, 8'd3));
        vecs.push_back(mk(4'b1111, 4'h0, BASE, 4'b1000, 8'h33, 3'd3, 8'd3));
        vecs.push_back(mk(4'b1111, 4'h0, BASE, 4'b0000, 8'h44, 3'd3, 8'd4));
        vecs.push_back(mk(4'b1111, 4'h0, BASE, 4'b0001, 8'h44, 3'd0, 8'd4));
        vecs.push_back(mk(4'b1111, 4'h0, BASE, 4'b0000, 8'h11, 3'd0, 8'd5));
        vecs.push_back(mk(4'b0100, 4'h4, BASE, 4'b0100, 8'h11, 3'd2, 8'd5));
        vecs.push_back(mk(4'b0100, 4'h4, 32'h44A02211, 4'b0100, 8'hA0, 3'd2, 8'd6));
        vecs.push_back(mk(4'b0100, 4'h4, 32'h44A12211, 4'b0100, 8'hA1, 3'd2, 8'd7));
        vecs.push_back(mk(4'b0100, 4'h4, 32'h44A22211, 4'b0100, 8'hA2, 3'd2, 8'd8));
        vecs.push_back(mk(4'b0100, 4'h4, 32'h44A32211, 4'b0000, 8'hA3, 3'd2, 8'd9));
        vecs.push_back(mk(4'b0100, 4'h4, 32'h44A32211, 4'b0100, 8'hA3, 3'd2, 8'd9));
        vecs.push_back(mk(4'b0100, 4'h4, 32'h44A42211, 4'b0100, 8'hA4, 3'd2, 8'd10));
        vecs.push_back(mk(4'b0000, 4'h0, 32'h44B02211, 4'b0000, 8'hA4, 3'd2, 8'd10));
        vecs.push_back(mk(4'b0000, 4'h0, BASE, 4'b0000, 8'hA4, 3'd2, 8'd10));
        vecs.push_back(mk(4'b1000, 4'h0, 32'hEE332211, 4'b1000, 8'hA4, 3'd3, 8'd10));
        vecs.push_back(mk(4'b0010, 4'h0, 32'hEE332211, 4'b0000, 8'hA4, 3'd3, 8'd10));
        vecs.push_back(mk(4'b0010, 4'h0, 32'hEE332211, 4'b0010, 8'hA4, 3'd1, 8'd10));
        vecs.push_back(mk(4'b0010, 4'h0, 32'hEE332211, 4'b0000, 8'h22, 3'd1, 8'd11));
        vecs.push_back(mk(4'b0100, 4'h0, 32'h445B2211, 4'b0100, 8'h22, 3'd2, 8'd11));
        vecs.push_back(mk(4'b0100, 4'h0, 32'h445B2211, 4'b0000, 8'h5B, 3'd2, 8'd12));
        vecs.push_back(mk(4'b1001, 4'h0, BASE, 4'b1000, 8'h5B, 3'd3, 8'd12));
        vecs.push_back(mk(4'b1001, 4'h0, BASE, 4'b0000, 8'h44, 3'd3, 8'd13));
        vecs.push_back(mk(4'b1001, 4'h0, BASE, 4'b0001, 8'h44, 3'd0, 8'd13));
        vecs.push_back(mk(4'b1001, 4'h0, BASE, 4'b0000, 8'h11, 3'd0, 8'd14));

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].req, vecs[i].lock, vecs[i].wdata);
            step();
            chk($sformatf("v%0d_gnt", i), 32'(bus.gnt), 32'(vecs[i].gnt));
            chk($sformatf("v%0d_q", i), 32'(bus.Q), 32'(vecs[i].q));
            chk($sformatf("v%0d_own", i), 32'(bus.owner), 32'(vecs[i].own));
            chk($sformatf("v%0d_cnt", i), 32'(bus.wr_cnt), 32'(vecs[i].cnt));
        end

        // Locked bursts of 4 from requester 0: 256 writes land at edge 320.
        do_reset();
        @(negedge clk);
        drive(4'b0001, 4'b0001, 32'h000000C3);
        for (int e = 1; e <= 319; e++) step();
        chk("wrap_cnt_255", 32'(bus.wr_cnt), 32'd255);
        chk("wrap_gnt_pre", 32'(bus.gnt), 32'h1);
        step();
        chk("wrap_cnt_0", 32'(bus.wr_cnt), 32'd0);
        chk("wrap_gnt_rel", 32'(bus.gnt), 32'h0);
        chk("wrap_q", 32'(bus.Q), 32'hC3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Round-robin arbiter that shares one WIDTH-bit storage register among NREQ requesters. Each requester raises a request, receives a registered one-hot grant, and writes its data slice into the shared register for one cycle or a locked burst. The block owns the register. It sits between independent producer blocks and the shared register that their results must pass through.

## Interface
- WIDTH, 8, data width of the shared register
- NREQ, 4, number of requesters (2..8)
- MAX_BURST, 4, maximum writes per grant when locked (1..15)
- clk  input  1  clock; all state changes on the rising edge
- clr  input  1  asynchronous, active-low reset
- req  input  NREQ  per-requester write request
- lock  input  NREQ  per-requester burst hold; sampled only while that requester owns the grant
- wdata  input  NREQ*WIDTH  requester i's data occupies bits [i*WIDTH +: WIDTH]
- gnt  output  NREQ  registered one-hot grant; all-zero when idle
- Q  output  WIDTH  shared register contents
- owner  output  3  index of the most recent grant winner
- wr_cnt  output  8  total committed writes; wraps at 256

## Operation
- FSM with two states:
  - IDLE: gnt = 0.
  - OWN: exactly one gnt bit is set.
- Reset (clr low, asynchronous, at any time including mid-burst) forces the following immediately, without waiting for a clock edge:
  - state = IDLE, gnt = 0, Q = 0, owner = 0, wr_cnt = 0
  - rr_ptr = 0, burst = 0
- IDLE, rising edge, req != 0:
  - The winner is the first set req bit searching upward from rr_ptr, wrapping from NREQ-1 to 0.
  - state -> OWN, gnt <= onehot(winner), owner <= winner.
  - rr_ptr <= (winner+1) mod NREQ, burst <= 0.
- IDLE, rising edge, req == 0: no change.
- OWN, rising edge, with owner o:
  - req[o] = 1: commit.
    - Q <= wdata slice o, wr_cnt <= wr_cnt+1, burst <= burst+1.
    - Release if lock[o] = 0 or burst+1 == MAX_BURST; otherwise stay in OWN.
  - req[o] = 0: no write; release.
  - Release means state -> IDLE and gnt <= 0 on that same edge.
- Requests from non-owners are ignored while in OWN. Only the owner's wdata slice can reach Q.
- After every release there is one IDLE cycle with gnt = 0 (turnaround) before the next grant. This holds even when req is still asserted.
- A requester that has just been served has lowest priority at the next arbitration.
- wr_cnt wraps 255 -> 0 with no flag.
- burst is a 4-bit counter. MAX_BURST = 1 makes lock ineffective.

## Timing
- Request to grant: req high before edge k in IDLE gives gnt high after edge k.
- Grant to first write: Q updates at edge k+1, provided req[o] is still high.
- Single write, lock = 0: gnt is high for exactly 1 cycle. The earliest next grant is at edge k+2.
- Locked burst of n writes (n <= MAX_BURST): gnt is high for n cycles with Q updating on every one of those edges.
- Q, gnt, owner and wr_cnt are all registered. There is no combinational path from inputs to outputs.
- Throughput: at most one write per cycle. Unlocked sharing gives one write per 2 cycles.

## Test plan
- Reset mid-burst:
  - Requester 1 is locked and has written 2 of 4, Q = 8'h5A. clr pulses low.
  - Required, immediately: gnt = 0, Q = 0, wr_cnt = 0.
  - After clr returns high with req = 4'b0011: requester 0 is granted first.
- Single writes, round-robin:
  - req = 4'b1111 held, lock = 0, wdata slices 8'h11/8'h22/8'h33/8'h44.
  - Required: gnt sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001.
  - Required: Q steps 11, 22, 33, 44, 11. wr_cnt increments once per grant.
- Locked burst cap:
  - req[2] = lock[2] = 1 held, MAX_BURST = 4, wdata2 changing each cycle A0, A1, A2, A3, A4.
  - Required: gnt = 0100 for exactly 4 cycles, Q = A0..A3, then one idle cycle, then requester 2 is regranted.
- Early drop:
  - Requester 3 is granted, then drops req[3] before the first write edge.
  - Required: no write (Q and wr_cnt unchanged), gnt returns to 0 after that edge, and the next pending requester wins.
- Wrap and fairness:
  - rr_ptr = 3 with req = 4'b1001: requester 3 wins, then requester 0.
  - 256 committed writes: wr_cnt returns to 0.
